// File: rtl/exec_pkg.sv
// Shared encodings for the RV32I execute stage: ALU opcodes, ResultSrc codes, branch funct3.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Branch condition on forwarded register operands; reserved funct3 codes never take.
  function automatic logic branch_cond(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    a_s = a;
    b_s = b;
    case (f3)
      F3_BEQ:  branch_cond = (a == b);
      F3_BNE:  branch_cond = (a != b);
      F3_BLT:  branch_cond = (a_s < b_s);
      F3_BGE:  branch_cond = (a_s >= b_s);
      F3_BLTU: branch_cond = (a < b);
      F3_BGEU: branch_cond = (a >= b);
      default: branch_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU (module rv_alu); opcode encoding lives in exec_pkg.
module rv_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] y
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic [4:0]             shamt;
  alu_op_e                op_e;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];
  assign op_e  = alu_op_e'(op);

  always_comb begin
    y = '0;
    case (op_e)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLT:   y = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:   y = a << shamt;
      ALU_SRL:   y = a >> shamt;
      ALU_SRA:   y = a_s >>> shamt;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the E/M register.
// Optional EXEC_PERF_CNT_EN adds retired-instruction and taken-redirect counters.
module execute_stage
  import exec_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BUBBLE_PC = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pcplus4_e,
  input  logic [XLEN-1:0] ext_imm_e,
  input  logic [4:0]      rs1_e,
  input  logic [4:0]      rs2_e,
  input  logic [4:0]      rd_e,
  input  logic [2:0]      funct3_e,
  input  logic            RegWrite_e,
  input  logic            MemWrite_e,
  input  logic            Jump_e,
  input  logic            Branch_e,
  input  logic            ALUSrc_e,
  input  logic [1:0]      ResultSrc_e,
  input  logic [3:0]      ALUControl_e,
  input  logic            AluAPc_e,
  input  logic            Jalr_e,
  input  logic [XLEN-1:0] result_w,
  input  logic [4:0]      rd_w,
  input  logic            RegWrite_w,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pcplus4_m,
  output logic [4:0]      rd_m,
  output logic [2:0]      funct3_m,
  output logic [1:0]      ResultSrc_m,
  output logic            RegWrite_m,
  output logic            MemWrite_m
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [31:0]     perf_instr_cnt,
  output logic [31:0]     perf_taken_cnt
`endif
);

  logic [XLEN-1:0] m_val;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] jalr_sum;

  // The M stage holds a JAL/JALR link value in pcplus4_m rather than in the ALU result.
  assign m_val = (ResultSrc_m == RES_PC4) ? pcplus4_m : alu_result_m;

  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      rs,
                                              input logic [XLEN-1:0] rf_val,
                                              input logic [XLEN-1:0] mv,
                                              input logic [4:0]      mrd,
                                              input logic            mwe,
                                              input logic [XLEN-1:0] wv,
                                              input logic [4:0]      wrd,
                                              input logic            wwe);
    if (mwe && (mrd != 5'd0) && (mrd == rs))      fwd_sel = mv;
    else if (wwe && (wrd != 5'd0) && (wrd == rs)) fwd_sel = wv;
    else                                          fwd_sel = rf_val;
  endfunction

  assign fwd_a = fwd_sel(rs1_e, rd1_e, m_val, rd_m, RegWrite_m, result_w, rd_w, RegWrite_w);
  assign fwd_b = fwd_sel(rs2_e, rd2_e, m_val, rd_m, RegWrite_m, result_w, rd_w, RegWrite_w);

  assign alu_a = AluAPc_e ? pc_e : fwd_a;
  assign alu_b = ALUSrc_e ? ext_imm_e : fwd_b;

  rv_alu #(.XLEN(XLEN)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (ALUControl_e),
    .y  (alu_y)
  );

  assign jalr_sum    = fwd_a + ext_imm_e;
  assign pc_src_e    = Jump_e | (Branch_e & branch_cond(funct3_e, fwd_a, fwd_b));
  assign pc_target_e = Jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_e + ext_imm_e);

  // E -> M register boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pcplus4_m    <= '0;
      rd_m         <= '0;
      funct3_m     <= '0;
      ResultSrc_m  <= '0;
      RegWrite_m   <= 1'b0;
      MemWrite_m   <= 1'b0;
    end else begin
      alu_result_m <= alu_y;
      write_data_m <= fwd_b;
      pcplus4_m    <= pcplus4_e;
      rd_m         <= rd_e;
      funct3_m     <= funct3_e;
      ResultSrc_m  <= ResultSrc_e;
      RegWrite_m   <= RegWrite_e;
      MemWrite_m   <= MemWrite_e;
    end
  end

`ifdef EXEC_PERF_CNT_EN
  logic real_instr;

  assign real_instr = (pc_e != BUBBLE_PC) &&
                      (RegWrite_e || MemWrite_e || Branch_e || Jump_e);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_instr_cnt <= '0;
      perf_taken_cnt <= '0;
    end else begin
      if (real_instr) perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (pc_src_e)   perf_taken_cnt <= perf_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected E/M contents queued at issue, popped one cycle later.
module tb_execute_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rd1_e, rd2_e, pc_e, pcplus4_e, ext_imm_e, result_w;
  logic [4:0]  rs1_e, rs2_e, rd_e, rd_w;
  logic [2:0]  funct3_e;
  logic        RegWrite_e, MemWrite_e, Jump_e, Branch_e, ALUSrc_e, AluAPc_e, Jalr_e, RegWrite_w;
  logic [1:0]  ResultSrc_e;
  logic [3:0]  ALUControl_e;
  logic        pc_src_e;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pcplus4_m;
  logic [4:0]  rd_m;
  logic [2:0]  funct3_m;
  logic [1:0]  ResultSrc_m;
  logic        RegWrite_m, MemWrite_m;
`ifdef EXEC_PERF_CNT_EN
  logic [31:0] perf_instr_cnt, perf_taken_cnt;
`endif

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e), .ext_imm_e(ext_imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .funct3_e(funct3_e),
    .RegWrite_e(RegWrite_e), .MemWrite_e(MemWrite_e), .Jump_e(Jump_e), .Branch_e(Branch_e),
    .ALUSrc_e(ALUSrc_e), .ResultSrc_e(ResultSrc_e), .ALUControl_e(ALUControl_e),
    .AluAPc_e(AluAPc_e), .Jalr_e(Jalr_e),
    .result_w(result_w), .rd_w(rd_w), .RegWrite_w(RegWrite_w),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pcplus4_m(pcplus4_m),
    .rd_m(rd_m), .funct3_m(funct3_m), .ResultSrc_m(ResultSrc_m),
    .RegWrite_m(RegWrite_m), .MemWrite_m(MemWrite_m)
`ifdef EXEC_PERF_CNT_EN
    , .perf_instr_cnt(perf_instr_cnt), .perf_taken_cnt(perf_taken_cnt)
`endif
  );

  typedef struct {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  rs;
    logic        rw, mw;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic bubble();
    rd1_e = '0; rd2_e = '0; pc_e = 32'hFFFF_FFFF; pcplus4_e = '0; ext_imm_e = '0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; funct3_e = '0;
    RegWrite_e = 0; MemWrite_e = 0; Jump_e = 0; Branch_e = 0; ALUSrc_e = 0;
    ResultSrc_e = RES_ALU; ALUControl_e = 4'd0; AluAPc_e = 0; Jalr_e = 0;
    result_w = '0; rd_w = '0; RegWrite_w = 0;
  endtask

  task automatic rand_in();
    rd1_e = $urandom; rd2_e = $urandom; pc_e = $urandom; pcplus4_e = $urandom;
    ext_imm_e = $urandom; result_w = $urandom;
    rs1_e = 5'($urandom); rs2_e = 5'($urandom); rd_e = 5'($urandom); rd_w = 5'($urandom);
    funct3_e = 3'($urandom); ResultSrc_e = 2'($urandom); ALUControl_e = 4'($urandom);
    {RegWrite_e, MemWrite_e, Jump_e, Branch_e, ALUSrc_e, AluAPc_e, Jalr_e, RegWrite_w} = 8'($urandom);
  endtask

  task automatic check_em_zero(input string tag);
    check({tag, "/alu"}, alu_result_m, 32'h0);
    check({tag, "/wd"},  write_data_m, 32'h0);
    check({tag, "/pc4"}, pcplus4_m,    32'h0);
    check({tag, "/ctl"}, {17'b0, rd_m, funct3_m, ResultSrc_m, RegWrite_m, MemWrite_m}, 32'h0);
  endtask

  // Called just after a negedge with E inputs set; returns at the following negedge.
  task automatic issue(input string tag, input logic [31:0] exp_alu, input logic [31:0] exp_wd,
                       input logic exp_src, input logic [31:0] exp_tgt);
    exp_t e;
    exp_t g;
    #1;
    check({tag, "/pc_src"}, {31'b0, pc_src_e}, {31'b0, exp_src});
    if (exp_src) check({tag, "/target"}, pc_target_e, exp_tgt);
    e.alu = exp_alu; e.wd = exp_wd; e.pc4 = pcplus4_e; e.rd = rd_e; e.f3 = funct3_e;
    e.rs = ResultSrc_e; e.rw = RegWrite_e; e.mw = MemWrite_e; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "/sb_empty"}, 32'h1, 32'h0);
    end else begin
      g = sb.pop_front();
      check({g.tag, "/alu_m"}, alu_result_m, g.alu);
      check({g.tag, "/wd_m"},  write_data_m, g.wd);
      check({g.tag, "/pc4_m"}, pcplus4_m,    g.pc4);
      check({g.tag, "/ctl_m"}, {17'b0, rd_m, funct3_m, ResultSrc_m, RegWrite_m, MemWrite_m},
            {17'b0, g.rd, g.f3, g.rs, g.rw, g.mw});
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, y;
  } alu_vec_t;

  alu_vec_t vecs[$] = '{
    '{4'd1,  32'd5,          32'd7,          32'hFFFF_FFFE},
    '{4'd2,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000},
    '{4'd3,  32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF},
    '{4'd4,  32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0},
    '{4'd5,  32'hFFFF_FFFF,  32'd1,          32'd1},
    '{4'd6,  32'hFFFF_FFFF,  32'd1,          32'd0},
    '{4'd7,  32'd1,          32'h0000_0021,  32'd2},
    '{4'd8,  32'h8000_0000,  32'd4,          32'h0800_0000},
    '{4'd9,  32'h8000_0000,  32'd4,          32'hF800_0000},
    '{4'd10, 32'd0,          32'h0000_1234,  32'h0000_1234},
    '{4'd15, 32'd5,          32'd6,          32'd0},
    '{4'd0,  32'hFFFF_FFFF,  32'd2,          32'd1}
  };

  initial begin
    bubble();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rand_in();
      @(posedge clk);
      #1;
      check_em_zero($sformatf("rst%0d", i));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x5 = 3 + 4; M register must still show reset contents before the edge
    bubble();
    rd1_e = 32'd3; rd2_e = 32'd4; rs1_e = 5'd1; rs2_e = 5'd2; rd_e = 5'd5; RegWrite_e = 1;
    pc_e = 32'h10; pcplus4_e = 32'h14; ALUControl_e = ALU_ADD;
    check("lat_pre/alu", alu_result_m, 32'h0);
    issue("add_x5", 32'd7, 32'd4, 1'b0, 32'h0);

    // SUB x6 = x5 - 1 with x5 forwarded from M
    bubble();
    rs1_e = 5'd5; rd1_e = 32'd99; ext_imm_e = 32'd1; ALUSrc_e = 1; ALUControl_e = ALU_SUB;
    rd_e = 5'd6; RegWrite_e = 1; pc_e = 32'h14;
    issue("sub_fwdM", 32'd6, 32'd0, 1'b0, 32'h0);

    // Same pair separated by a NOP: x5 comes from W
    bubble();
    rd1_e = 32'd3; rd2_e = 32'd4; rs1_e = 5'd1; rs2_e = 5'd2; rd_e = 5'd5; RegWrite_e = 1;
    pc_e = 32'h20; ALUControl_e = ALU_ADD;
    issue("add_x5b", 32'd7, 32'd4, 1'b0, 32'h0);
    bubble();
    issue("nop", 32'd0, 32'd0, 1'b0, 32'h0);
    bubble();
    rs1_e = 5'd5; rd1_e = 32'd99; ext_imm_e = 32'd1; ALUSrc_e = 1; ALUControl_e = ALU_SUB;
    rd_e = 5'd6; RegWrite_e = 1; pc_e = 32'h28;
    rd_w = 5'd5; result_w = 32'd7; RegWrite_w = 1;
    issue("sub_fwdW", 32'd6, 32'd0, 1'b0, 32'h0);

    // M beats W for the same register; B side forwards too
    bubble();
    ext_imm_e = 32'd10; ALUSrc_e = 1; ALUControl_e = ALU_PASSB; rd_e = 5'd7; RegWrite_e = 1;
    pc_e = 32'h30;
    issue("x7_10", 32'd10, 32'd0, 1'b0, 32'h0);
    bubble();
    rs1_e = 5'd7; rd1_e = 32'd1; rs2_e = 5'd7; rd2_e = 32'd3; ALUSrc_e = 1;
    ALUControl_e = ALU_ADD; rd_e = 5'd8; RegWrite_e = 1; pc_e = 32'h34;
    rd_w = 5'd7; result_w = 32'd20; RegWrite_w = 1;
    issue("prio_MW", 32'd10, 32'd10, 1'b0, 32'h0);

    // x0 is never forwarded, from M or W
    bubble();
    ext_imm_e = 32'd55; ALUSrc_e = 1; ALUControl_e = ALU_PASSB; rd_e = 5'd0; RegWrite_e = 1;
    pc_e = 32'h38;
    issue("x0_wr", 32'd55, 32'd0, 1'b0, 32'h0);
    bubble();
    rs1_e = 5'd0; rd1_e = 32'h33; ALUSrc_e = 1; ALUControl_e = ALU_ADD; pc_e = 32'h3C;
    rd_w = 5'd0; result_w = 32'd99; RegWrite_w = 1;
    issue("x0_nofwd", 32'h33, 32'd0, 1'b0, 32'h0);

    // Branches: compare uses registers, never the immediate
    bubble();
    Branch_e = 1; funct3_e = F3_BLT; rs1_e = 5'd10; rs2_e = 5'd11;
    rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1; ALUSrc_e = 1; ext_imm_e = 32'hFFFF_FFF8;
    pc_e = 32'h100; pcplus4_e = 32'h104; ALUControl_e = ALU_SUB;
    issue("blt", 32'd7, 32'd1, 1'b1, 32'h0000_00F8);
    funct3_e = F3_BLTU;
    issue("bltu", 32'd7, 32'd1, 1'b0, 32'h0);
    funct3_e = F3_BGE;
    issue("bge", 32'd7, 32'd1, 1'b0, 32'h0);
    funct3_e = F3_BGEU;
    issue("bgeu", 32'd7, 32'd1, 1'b1, 32'h0000_00F8);
    rd1_e = 32'd5; rd2_e = 32'd5; funct3_e = F3_BEQ;
    issue("beq", 32'd13, 32'd5, 1'b1, 32'h0000_00F8);
    funct3_e = F3_BNE;
    issue("bne", 32'd13, 32'd5, 1'b0, 32'h0);
    funct3_e = 3'b010;
    issue("br_rsvd", 32'd13, 32'd5, 1'b0, 32'h0);

    // JALR target clears bit 0
    bubble();
    Jump_e = 1; Jalr_e = 1; rs1_e = 5'd12; rd1_e = 32'h203; ext_imm_e = 32'd2; ALUSrc_e = 1;
    ALUControl_e = ALU_ADD; rd_e = 5'd1; RegWrite_e = 1; ResultSrc_e = RES_PC4;
    pc_e = 32'h300; pcplus4_e = 32'h304;
    issue("jalr", 32'h205, 32'd0, 1'b1, 32'h0000_0204);

    // JAL then ADD reading the link register: forwarded value is pcplus4_m
    bubble();
    Jump_e = 1; ext_imm_e = 32'h10; ALUSrc_e = 1; ALUControl_e = ALU_ADD;
    rd_e = 5'd1; RegWrite_e = 1; ResultSrc_e = RES_PC4; pc_e = 32'h400; pcplus4_e = 32'h404;
    issue("jal", 32'h10, 32'd0, 1'b1, 32'h0000_0410);
    bubble();
    rs1_e = 5'd1; rd1_e = 32'd0; ALUSrc_e = 1; ALUControl_e = ALU_ADD; rd_e = 5'd2;
    RegWrite_e = 1; pc_e = 32'h404;
    issue("jal_fwd", 32'h404, 32'd0, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      bubble();
      rd1_e = vecs[i].a; rd2_e = vecs[i].b; ALUControl_e = vecs[i].op; rd_e = 5'd3;
      RegWrite_e = 1; pc_e = 32'h500 + 32'(i * 4);
      issue($sformatf("alu_op%0d", vecs[i].op), vecs[i].y, vecs[i].b, 1'b0, 32'h0);
    end

    // AUIPC-style: A operand is pc_e
    bubble();
    AluAPc_e = 1; pc_e = 32'h1000; ext_imm_e = 32'h2000; ALUSrc_e = 1; rd1_e = 32'hDEAD;
    ALUControl_e = ALU_ADD; rd_e = 5'd4; RegWrite_e = 1;
    issue("auipc", 32'h3000, 32'd0, 1'b0, 32'h0);

    // Reset mid-operation drops the in-flight instruction
    bubble();
    rd1_e = 32'd9; rd2_e = 32'd9; rd_e = 5'd9; RegWrite_e = 1; MemWrite_e = 1; pc_e = 32'h600;
    pcplus4_e = 32'h604;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_em_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef EXEC_PERF_CNT_EN
    check("perf_rst/instr", perf_instr_cnt, 32'd0);
    check("perf_rst/taken", perf_taken_cnt, 32'd0);
    bubble();
    rd1_e = 32'd1; rd2_e = 32'd2; rd_e = 5'd3; RegWrite_e = 1; pc_e = 32'h700;
    issue("perf_add", 32'd3, 32'd2, 1'b0, 32'h0);
    ALUControl_e = ALU_SUB; pc_e = 32'h704;
    issue("perf_sub", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0);
    bubble();
    Branch_e = 1; funct3_e = F3_BEQ; pc_e = 32'h708; ext_imm_e = 32'h8;
    issue("perf_beq", 32'd0, 32'd0, 1'b1, 32'h0000_0710);
    bubble();
    issue("perf_nop1", 32'd0, 32'd0, 1'b0, 32'h0);
    issue("perf_nop2", 32'd0, 32'd0, 1'b0, 32'h0);
    check("perf/instr", perf_instr_cnt, 32'd3);
    check("perf/taken", perf_taken_cnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
